pc_redirect_unit: RTL

// - Consumer side of the ALU result interface: owns the PC register and turns the EX-stage

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_target_calc.sv | 48 ++++
 rtl/pc_redirect_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared PC-redirect types and constants.
// Latency: none (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // Fetch sequencer state: running normally, or parked on the halt target.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

    // Sequential fetch advance in bytes (one 32-bit instruction).
    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Computes the redirect target for a taken branch/JAL/JALR and flags halt requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the target is used.
//
// Ports:
//   jalr      in   1           select the JALR target (has priority over branch/JAL)
//   jalr_src  in   DATA_WIDTH  rs1+imm from the ALU
//   imm       in   DATA_WIDTH  sign-extended branch/JAL offset
//   ex_pc     in   PC_W        PC of the EX-stage instruction
//   target    out  PC_W        PC to load: word-aligned target, or HALT_PC on a halt request
//   is_halt   out  1           raw target equals the reserved halt address
module pc_target_calc #(
    parameter int              DATA_WIDTH = 32,
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] HALT_PC    = 9'h1FF
) (
    input  logic                  jalr,
    input  logic [DATA_WIDTH-1:0] jalr_src,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [PC_W-1:0]       ex_pc,
    output logic [PC_W-1:0]       target,
    output logic                  is_halt
);

    logic [PC_W-1:0] raw_target;

    // Only the low PC_W bits matter: PC arithmetic is modulo 2^PC_W, and JALR
    // drops bit 0 by definition.
    logic unused_bits;
    assign unused_bits = ^{jalr_src[DATA_WIDTH-1:PC_W], jalr_src[0], imm[DATA_WIDTH-1:PC_W]};

    always_comb begin
        raw_target = ex_pc + imm[PC_W-1:0];
        if (jalr) begin
            raw_target = {jalr_src[PC_W-1:1], 1'b0};
        end
    end

    // HALT_PC is deliberately unaligned so it can never be a real fetch
    // address; it is matched before alignment. A JALR target has bit 0
    // already cleared, so an odd HALT_PC is reachable only via branch/JAL.
    // Every other target is then forced onto a word boundary.
    always_comb begin
        is_halt = (raw_target == HALT_PC);
        target  = is_halt ? HALT_PC : {raw_target[PC_W-1:2], 2'b00};
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC: sequential advance, EX-stage redirects with IF/ID flush, and halt.
// Latency: redirect is zero-latency (flush same cycle, target fetched next cycle).
// Backpressure: stall holds the PC unless a redirect is taken; halt freezes everything until reset.
//
// Ports:
//   clk             in   1           clock, rising edge
//   reset           in   1           asynchronous, active-high
//   stall           in   1           hazard stall; hold PC
//   branch/jal/jalr in   1           EX instruction type flags
//   ALUResult       in   DATA_WIDTH  bit 0 = branch condition true
//   jalr_src        in   DATA_WIDTH  JALR target from the ALU
//   imm             in   DATA_WIDTH  branch/JAL offset
//   ex_pc           in   PC_W        PC of the EX-stage instruction
//   pc              out  PC_W        registered fetch PC
//   flush           out  1           combinational kill of IF/ID and ID/EX
//   halted          out  1           registered halt status
//   redirect_count  out  CNT_W       saturating count of taken redirects
module pc_redirect_unit #(
    parameter int              DATA_WIDTH = 32,
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] HALT_PC    = 9'h1FF,
    parameter int              CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  jal,
    input  logic                  jalr,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] jalr_src,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [PC_W-1:0]       ex_pc,
    output logic [PC_W-1:0]       pc,
    output logic                  flush,
    output logic                  halted,
    output logic [CNT_W-1:0]      redirect_count
);

    import riscv_pkg::*;

    pc_state_t       state;
    logic            take;
    logic [PC_W-1:0] target;
    logic            is_halt;

    // Only the branch condition bit of the ALU result is consumed here.
    logic unused_alu;
    assign unused_alu = ^ALUResult[DATA_WIDTH-1:1];

    pc_target_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_W       (PC_W),
        .HALT_PC    (HALT_PC)
    ) u_target (
        .jalr     (jalr),
        .jalr_src (jalr_src),
        .imm      (imm),
        .ex_pc    (ex_pc),
        .target   (target),
        .is_halt  (is_halt)
    );

    // A branch redirects only when its compare is true; a stray ALUResult[0]
    // from a non-branch instruction must never redirect.
    assign take = (state == RUN) && ((branch && ALUResult[0]) || jal || jalr);

    // Gated by reset so a redirect caught under reset never kills the
    // instructions fetched right after release.
    assign flush = take && !reset;

    assign halted = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pc             <= '0;
            redirect_count <= '0;
        end else if (state == RUN) begin
            if (take) begin
                // Redirect beats stall: the wrong-path instruction causing
                // the stall is being flushed anyway.
                pc <= target;
                if (is_halt) begin
                    state <= HALT;
                end
                if (redirect_count != '1) begin
                    redirect_count <= redirect_count + 1'b1;
                end
            end else if (!stall) begin
                pc <= pc + PC_W'(PC_STEP);
            end
        end
        // HALT: pc, state and counter are frozen until reset.
    end

endmodule
